load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Sits between the CPU execute stage and data_memory (word-indexed, 1-cycle registered read, no byte enables).
//  Accepts byte/half/word load/store requests on byte addresses; converts to word index; sign/zero-extends loads.
//  Sub-word stores use a read-modify-write sequence. Misaligned, illegal-size and out-of-range requests get an error response.
// PARAMETERS
//  data_size  32    data/address width; only 32 supported
//  mem_size   1024  data_memory depth in words; word index >= mem_size is out of range
// PORTS
//  clk            in   1   clock; all state updates on rising edge
//  rst_n          in   1   synchronous, active-low reset
//  req_valid      in   1   request present
//  req_ready      out  1   unit can accept; high only in IDLE
//  req_write      in   1   1=store, 0=load
//  req_size       in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned   in   1   loads: 1 zero-extend, 0 sign-extend
//  req_addr       in   32  byte address
//  req_wdata      in   32  store data, right-justified
//  resp_valid     out  1   one-cycle pulse; no backpressure
//  resp_err       out  1   valid with resp_valid; 1 = misaligned/illegal/out-of-range
//  resp_rdata     out  32  load result; 0 for stores and errors
//  mem_write_en   out  1   to data_memory write_en
//  mem_addr       out  32  word index = addr_q[31:2], upper bits 0
//  mem_write_data out  32  full word to write
//  mem_rdata      in   32  data_memory read data, valid the cycle after mem_addr
// BEHAVIOUR
//  Reset (rst_n low at edge): state IDLE; resp_valid=0, resp_err=0, resp_rdata=0, captured regs=0.
//   mem_write_en is ANDed with rst_n: no write in any cycle where rst_n is low. Memory contents untouched.
//   Reset mid-operation abandons the request; no response is issued.
//  Handshake: accept on edge with req_valid && req_ready; capture all req_* fields. req_ready=0 otherwise.
//  Error check at accept: size==11; half with addr[0]!=0; word with addr[1:0]!=0; addr[31:2]>=mem_size.
//  States:
//   IDLE     req_ready=1. On accept: error->RESP(err); load or sub-word store->RD_ISSUE; word store->WR.
//   RD_ISSUE mem_addr driven, mem_write_en=0 -> RD_WAIT.
//   RD_WAIT  mem_rdata valid. Load: register extracted+extended data -> RESP.
//            Store: register merged word (replace addressed byte/half lanes with req_wdata[7:0]/[15:0]) -> WR.
//   WR       mem_write_en=1, mem_write_data = merged word (sub-word) or wdata_q (word) -> RESP.
//   RESP     resp_valid=1 for exactly one cycle -> IDLE.
//  Latency from accept edge to resp_valid cycle: error 1, word store 2, load 3, sub-word store 4.
//  Extraction: byte lane = addr[1:0], half lane = addr[1]; little-endian lane order.
//  mem_write_en=0 in every state except WR. mem_addr holds the last captured index between requests.
//  Requests presented while busy are ignored (not captured); requester must hold until req_ready.
//  Back-to-back: next request can be accepted in the cycle after RESP.
// STRUCTURE
//  lsu_pkg: size enum (SZ_BYTE/SZ_HALF/SZ_WORD/SZ_BAD), state enum, RESP_DATA_ERR=32'h0.
//  Sub-module lsu_align (combinational): load extract/extend and store lane merge, from size, unsigned, addr[1:0].
//  Top: FSM, capture regs, error check, response regs. Bench instantiates top with data_memory.
// TESTING
//  1 Word store 0xDEADBEEF @0x10, then load word @0x10 -> mem[4]=DEADBEEF; resp_rdata=DEADBEEF 3 cycles after accept.
//  2 Byte loads from 0x10..0x13, signed -> EF->FFFFFFEF, BE->FFFFFFBE, AD->FFFFFFAD, DE->FFFFFFDE; unsigned -> 000000EF etc.
//  3 Half store 0x1234 @0x12 over DEADBEEF -> mem[4]=1234BEEF; resp 4 cycles after accept; exactly one write pulse.
//  4 Word load @0x11, half @0x13, size 11, word @0x1000 (index 1024) -> resp_err=1 at +1 cycle, rdata=0, no mem write.
//  5 rst_n low during WR of sub-word store -> no write, mem[4] unchanged, no resp_valid; next request works normally.
//  6 req_valid held continuously for 3 requests -> each accepted only in IDLE; responses in order, one per request.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MEM_DEPTH = 1024;

  localparam logic [DATA_W-1:0] RESP_DATA_ERR = 32'h0;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_WR,
    ST_RESP
  } state_e;

  // Request fields kept for the whole transaction; lane is addr[1:0].
  typedef struct packed {
    logic              write;
    size_e             size;
    logic              is_unsigned;
    logic [1:0]        lane;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/lsu_align.sv
// Lane steering: load extract/extend and sub-word store merge, little-endian.
module lsu_align
  import lsu_pkg::*;
(
  input  size_e             i_size,
  input  logic              i_unsigned,
  input  logic [1:0]        i_lane,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_load_data_c,
  output logic [DATA_W-1:0] o_merged_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte        = i_rdata[{i_lane, 3'b000} +: 8];
    w_half        = i_rdata[{i_lane[1], 4'b0000} +: 16];
    o_load_data_c = i_rdata;
    o_merged_c    = i_wdata;
    case (i_size)
      SZ_BYTE: begin
        o_load_data_c = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
        o_merged_c    = i_rdata;
        o_merged_c[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
      end
      SZ_HALF: begin
        o_load_data_c = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
        o_merged_c    = i_rdata;
        o_merged_c[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-indexed, 1-cycle-read data memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned data_size = DATA_W,
  parameter int unsigned mem_size  = MEM_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [data_size-1:0] req_addr,
  input  logic [data_size-1:0] req_wdata,
  output logic                 resp_valid,
  output logic                 resp_err,
  output logic [data_size-1:0] resp_rdata,
  output logic                 mem_write_en,
  output logic [data_size-1:0] mem_addr,
  output logic [data_size-1:0] mem_write_data,
  input  logic [data_size-1:0] mem_rdata
);

  state_e            r_state;
  req_t              r_req;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_wr_en;
  logic [DATA_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  size_e             w_size;
  logic [DATA_W-1:0] w_index;
  logic              w_err;
  logic [DATA_W-1:0] w_load_data;
  logic [DATA_W-1:0] w_merged;

  // Request screening on the incoming fields, used only at accept.
  always_comb begin
    w_size  = size_e'(req_size);
    w_index = {2'b00, req_addr[31:2]};
    w_err   = 1'b0;
    case (w_size)
      SZ_BAD:  w_err = 1'b1;
      SZ_HALF: w_err = req_addr[0];
      SZ_WORD: w_err = |req_addr[1:0];
      default: w_err = 1'b0;
    endcase
    if (w_index >= 32'(mem_size)) begin
      w_err = 1'b1;
    end
  end

  lsu_align u_align (
    .i_size        (r_req.size),
    .i_unsigned    (r_req.is_unsigned),
    .i_lane        (r_req.lane),
    .i_rdata       (mem_rdata),
    .i_wdata       (r_req.wdata),
    .o_load_data_c (w_load_data),
    .o_merged_c    (w_merged)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_req        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_wr_en      <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_wr_en      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_req       <= '{write: req_write, size: w_size, is_unsigned: req_unsigned,
                             lane: req_addr[1:0], wdata: req_wdata};
            r_mem_addr  <= w_index;
            r_req_ready <= 1'b0;
            if (w_err) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= RESP_DATA_ERR;
            end else if (req_write && (w_size == SZ_WORD)) begin
              r_state     <= ST_WR;
              r_wr_en     <= 1'b1;
              r_mem_wdata <= req_wdata;
            end else begin
              r_state <= ST_RD_ISSUE;
            end
          end
        end
        ST_RD_ISSUE: r_state <= ST_RD_WAIT;
        ST_RD_WAIT: begin
          if (r_req.write) begin
            r_state     <= ST_WR;
            r_wr_en     <= 1'b1;
            r_mem_wdata <= w_merged;
          end else begin
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= w_load_data;
          end
        end
        ST_WR: begin
          r_state      <= ST_RESP;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= '0;
        end
        ST_RESP: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  // Write strobe is gated by reset so an abandoned WR never reaches memory.
  assign mem_write_en   = r_wr_en & rst_n;
  assign req_ready      = r_req_ready;
  assign resp_valid     = r_resp_valid;
  assign resp_err       = r_resp_err;
  assign resp_rdata     = r_resp_rdata;
  assign mem_addr       = r_mem_addr;
  assign mem_write_data = r_mem_wdata;

endmodule
